// File: rtl/gpu_rasterizer.sv
// rtl/gpu_rasterizer.sv - rectangle rasterizer draining the GPU op FIFO into the 1-bit back framebuffer
//
// Purpose:
//   Pops gpu_op_t rectangles from a standard (non show-ahead) FIFO and writes
//   one framebuffer pixel per enabled cycle in raster order. Pixels come from
//   the op's solid colour or from the sprite ROM, optionally at 2x scale.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   ce                clock enable; low freezes all state and suppresses strobes
//   op                op at the FIFO head, valid the cycle after op_rd_en
//   op_rd_en, op_empty FIFO pop strobe and empty flag
//   sprite_rd_addr    sprite ROM address; sprite_rd_data returns one cycle later
//   fb_wr_en, fb_wr_addr, fb_wr_data  framebuffer write port
//   idle              FIFO drained and no write pending

package gpu_rasterizer_pkg;

    localparam int GPU_SPRITE_ADDR_WIDTH = 12;

    typedef struct packed {
        logic [10:0]                      x;
        logic [10:0]                      y;
        logic [10:0]                      width;
        logic [10:0]                      height;
        logic                             color;
        logic                             mem_en;
        logic                             scale;
        logic [GPU_SPRITE_ADDR_WIDTH-1:0] mem_addr;
    } gpu_op_t;

endpackage

module gpu_rasterizer
    import gpu_rasterizer_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int FB_ADDR_WIDTH     = 19,
    // Must match GPU_SPRITE_ADDR_WIDTH, which sizes gpu_op_t.mem_addr.
    parameter int SPRITE_ADDR_WIDTH = GPU_SPRITE_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce,
    input  gpu_op_t                      op,
    output logic                         op_rd_en,
    input  logic                         op_empty,
    output logic [SPRITE_ADDR_WIDTH-1:0] sprite_rd_addr,
    input  logic                         sprite_rd_data,
    output logic                         fb_wr_en,
    output logic [FB_ADDR_WIDTH-1:0]     fb_wr_addr,
    output logic                         fb_wr_data,
    output logic                         idle
);

    localparam logic [11:0]              HOR_PX     = 12'(HOR_ACTIVE_PIXELS);
    localparam logic [11:0]              VER_PX     = 12'(VER_ACTIVE_PIXELS);
    localparam logic [FB_ADDR_WIDTH-1:0] ROW_STRIDE = FB_ADDR_WIDTH'(HOR_ACTIVE_PIXELS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_DRAW,
        ST_FLUSH
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                         state_q, state_d;

    // Latched op
    logic [10:0]                    x_q, x_d;
    logic [10:0]                    y_q, y_d;
    logic [10:0]                    w_q, w_d;
    logic [10:0]                    h_q, h_d;
    logic                           color_q, color_d;
    logic                           mem_en_q, mem_en_d;
    logic                           scale_q, scale_d;

    // Walk counters (stage 0)
    logic [10:0]                    col_q, col_d;
    logic [10:0]                    row_q, row_d;
    logic [SPRITE_ADDR_WIDTH-1:0]   tex_row_base_q, tex_row_base_d;
    logic [10:0]                    stride_q, stride_d;
    // Framebuffer address of (x, y+row); advanced by one stride per row so
    // no multiplier sits in the per-pixel path.
    logic [FB_ADDR_WIDTH-1:0]       row_addr_q, row_addr_d;

    // Stage 1 (write) register
    logic                           s1_valid_q, s1_valid_d;
    logic                           s1_inb_q, s1_inb_d;
    logic [FB_ADDR_WIDTH-1:0]       s1_addr_q, s1_addr_d;
    logic                           s1_mem_en_q, s1_mem_en_d;
    logic                           s1_color_q, s1_color_d;

    logic                           idle_q, idle_d;

    // Texel capture: the ROM is not clock-enabled, so once ce drops the ROM
    // output moves on to the next stage-0 address. tex_fresh_q marks cycles
    // where sprite_rd_data still belongs to the stage-1 pixel; otherwise the
    // copy taken on that first cycle is used.
    logic                           tex_fresh_q;
    logic                           tex_hold_q;
    logic                           texel;

    // ------------------------------------------------------------------
    // Stage 0 combinational helpers
    // ------------------------------------------------------------------
    logic [11:0]                    px;
    logic [11:0]                    py;
    logic                           last_col;
    logic                           last_row;
    logic [SPRITE_ADDR_WIDTH-1:0]   tex_col;
    logic                           idle_now;

    // 12-bit sums so a rectangle running off the right/bottom edge clips
    // instead of wrapping.
    assign px       = {1'b0, x_q} + {1'b0, col_q};
    assign py       = {1'b0, y_q} + {1'b0, row_q};
    assign last_col = (col_q == (w_q - 11'd1));
    assign last_row = (row_q == (h_q - 11'd1));
    assign tex_col  = SPRITE_ADDR_WIDTH'(col_q >> scale_q);
    assign idle_now = (state_q == ST_IDLE) && op_empty && !s1_valid_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        y_d            = y_q;
        w_d            = w_q;
        h_d            = h_q;
        color_d        = color_q;
        mem_en_d       = mem_en_q;
        scale_d        = scale_q;
        col_d          = col_q;
        row_d          = row_q;
        tex_row_base_d = tex_row_base_q;
        stride_d       = stride_q;
        row_addr_d     = row_addr_q;
        s1_valid_d     = 1'b0;
        s1_inb_d       = s1_inb_q;
        s1_addr_d      = s1_addr_q;
        s1_mem_en_d    = s1_mem_en_q;
        s1_color_d     = s1_color_q;
        idle_d         = idle_now;

        case (state_q)
            ST_IDLE: begin
                if (!op_empty) begin
                    state_d = ST_LATCH;
                end
            end

            ST_LATCH: begin
                x_d      = op.x;
                y_d      = op.y;
                w_d      = op.width;
                h_d      = op.height;
                color_d  = op.color;
                mem_en_d = op.mem_en;
                scale_d  = op.scale;
                col_d    = 11'd0;
                row_d    = 11'd0;
                if ((op.width == 11'd0) || (op.height == 11'd0)) begin
                    state_d = ST_IDLE;
                end else begin
                    tex_row_base_d = SPRITE_ADDR_WIDTH'(op.mem_addr);
                    stride_d       = op.width >> op.scale;
                    // Constant-coefficient product, evaluated once per op.
                    row_addr_d     = (FB_ADDR_WIDTH'(op.y) * ROW_STRIDE) + FB_ADDR_WIDTH'(op.x);
                    state_d        = ST_DRAW;
                end
            end

            ST_DRAW: begin
                s1_valid_d  = 1'b1;
                s1_inb_d    = (px < HOR_PX) && (py < VER_PX);
                s1_addr_d   = row_addr_q + FB_ADDR_WIDTH'(col_q);
                s1_mem_en_d = mem_en_q;
                s1_color_d  = color_q;
                if (last_col) begin
                    col_d = 11'd0;
                    if (last_row) begin
                        state_d = ST_FLUSH;
                    end else begin
                        row_d      = row_q + 11'd1;
                        row_addr_d = row_addr_q + ROW_STRIDE;
                        // At 2x a texel row covers two screen rows: advance
                        // only after the odd one.
                        if (!scale_q || row_q[0]) begin
                            tex_row_base_d = tex_row_base_q + SPRITE_ADDR_WIDTH'(stride_q);
                        end
                    end
                end else begin
                    col_d = col_q + 11'd1;
                end
            end

            ST_FLUSH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            x_q            <= '0;
            y_q            <= '0;
            w_q            <= '0;
            h_q            <= '0;
            color_q        <= 1'b0;
            mem_en_q       <= 1'b0;
            scale_q        <= 1'b0;
            col_q          <= '0;
            row_q          <= '0;
            tex_row_base_q <= '0;
            stride_q       <= '0;
            row_addr_q     <= '0;
            s1_valid_q     <= 1'b0;
            s1_inb_q       <= 1'b0;
            s1_addr_q      <= '0;
            s1_mem_en_q    <= 1'b0;
            s1_color_q     <= 1'b0;
            idle_q         <= 1'b1;
        end else if (ce) begin
            state_q        <= state_d;
            x_q            <= x_d;
            y_q            <= y_d;
            w_q            <= w_d;
            h_q            <= h_d;
            color_q        <= color_d;
            mem_en_q       <= mem_en_d;
            scale_q        <= scale_d;
            col_q          <= col_d;
            row_q          <= row_d;
            tex_row_base_q <= tex_row_base_d;
            stride_q       <= stride_d;
            row_addr_q     <= row_addr_d;
            s1_valid_q     <= s1_valid_d;
            s1_inb_q       <= s1_inb_d;
            s1_addr_q      <= s1_addr_d;
            s1_mem_en_q    <= s1_mem_en_d;
            s1_color_q     <= s1_color_d;
            idle_q         <= idle_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tex_fresh_q <= 1'b0;
            tex_hold_q  <= 1'b0;
        end else begin
            tex_fresh_q <= ce;
            if (tex_fresh_q) begin
                tex_hold_q <= sprite_rd_data;
            end
        end
    end

    assign texel = tex_fresh_q ? sprite_rd_data : tex_hold_q;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The pop is combinational so the FIFO samples it on the IDLE->LATCH
    // edge and presents the op during LATCH.
    assign op_rd_en       = !rst && ce && (state_q == ST_IDLE) && !op_empty;
    assign sprite_rd_addr = tex_row_base_q + tex_col;
    assign fb_wr_en       = ce && s1_valid_q && s1_inb_q;
    assign fb_wr_addr     = s1_addr_q;
    assign fb_wr_data     = s1_mem_en_q ? texel : s1_color_q;
    assign idle           = idle_q && idle_now;

endmodule

// File: doc/gpu_rasterizer.md
Name: gpu_rasterizer

Overview:
- Consumer end of the GPU op FIFO. The CPU writes `gpu_op_t` ops into that FIFO; this block pops them and rasterizes each op into the 1-bit back framebuffer.
- Each op is an axis-aligned rectangle. Its pixels come either from a solid colour or from sprite memory, optionally at 2x scale.
- Sits between the op FIFO, the sprite ROM and the framebuffer write port. It reports idle status for the frame-swap logic.

Parameters:
- HOR_ACTIVE_PIXELS, 640, framebuffer width in pixels; row stride of the framebuffer.
- VER_ACTIVE_PIXELS, 480, framebuffer height in pixels.
- FB_ADDR_WIDTH, 19, framebuffer address width; must satisfy 2^FB_ADDR_WIDTH >= HOR*VER.
- SPRITE_ADDR_WIDTH, 12, sprite ROM address width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ce  in  1  clock enable; when low, all state, pipeline and outputs hold, and no strobes are issued
- op  in  gpu_op_t  op from FIFO head (x, y, width, height: 11 bits each; color, mem_en, scale: 1 bit each; mem_addr: SPRITE_ADDR_WIDTH bits)
- op_rd_en  out  1  FIFO pop strobe
- op_empty  in  1  FIFO empty flag
- sprite_rd_addr  out  SPRITE_ADDR_WIDTH  sprite ROM address
- sprite_rd_data  in  1  sprite texel; valid 1 cycle after the address is presented
- fb_wr_en  out  1  framebuffer write strobe
- fb_wr_addr  out  FB_ADDR_WIDTH  framebuffer write address, y*HOR_ACTIVE_PIXELS + x
- fb_wr_data  out  1  pixel value
- idle  out  1  high when the FIFO is drained and no write is pending

Behaviour:
- Reset values: op_rd_en=0, fb_wr_en=0, fb_wr_addr=0, fb_wr_data=0, sprite_rd_addr=0, idle=1, state=IDLE, pipeline valids=0.
- Reset mid-op aborts the op and drops any pending write. The popped op is lost.
- The FIFO is standard (not show-ahead): `op` is valid the cycle after op_rd_en is sampled high.
- States:
  - IDLE: if !op_empty, pulse op_rd_en for exactly 1 cycle and go to LATCH. idle=1 only in IDLE with op_empty=1 and the pipeline empty.
  - LATCH: capture `op` into internal registers and clear col=row=0.
    - If width==0 or height==0, go to IDLE; no writes.
    - Otherwise set tex_row_base=mem_addr and stride=width>>scale, then go to DRAW.
  - DRAW: emit one pixel per enabled cycle, raster order (col fastest).
    - Stage 0: px=x+col, py=y+row, sprite_rd_addr=tex_row_base+(col>>scale).
    - Stage 1 (next cycle): fb_wr_en=1 if px<HOR and py<VER; else suppress the write (clip).
    - Stage 1 data: fb_wr_data = mem_en ? sprite_rd_data : color. fb_wr_addr = py*HOR+px, computed incrementally with no runtime multiplier.
    - End of row: col=0, row++. tex_row_base += stride when scale==0, or when scale==1 and the row just finished is odd.
    - After the last pixel (col=width-1, row=height-1), go to FLUSH.
  - FLUSH: one cycle to retire stage 1, then IDLE. Back-to-back ops therefore cost 3 cycles of overhead each.
- Sprite texel size:
  - scale=1: each texel covers 2x2 pixels. width and height are in screen pixels; texel column = col>>1.
  - scale=0: texels map 1:1 to pixels.
- Arithmetic: px and py are 12-bit unsigned, so x+width overflow is caught by the clip compare. No wrap to the next row or line.
- op_rd_en is never asserted outside IDLE. Ops are never reordered or skipped.
- A draw of W*H pixels takes exactly W*H enabled DRAW cycles, plus LATCH and FLUSH.

Test Plan:
- Solid fill: op{x=0,y=0,w=640,h=480,color=0,mem_en=0} -> 307200 writes, addresses 0..307199 in order, data 0; idle rises 2 cycles after the last write.
- Clip: op{x=620,y=470,w=40,h=24,color=1} -> only the 20x10 in-bounds pixels are written; first address 470*640+620=301420; no address >=307200.
- Sprite 2x: op{x=20,y=228,w=34,h=24,mem_en=1,mem_addr=0,scale=1}, ROM = address LSB -> sprite addresses for rows 0-1 span 0..16, rows 2-3 span 17..33; pixel pairs are equal.
- Zero size: op{w=0,h=5} followed by op{w=1,h=1,x=3,y=2} -> exactly one write, at 1283; exactly two pops.
- ce gating: toggle ce 50% pseudo-randomly during a 4x4 fill -> the same 16 writes in the same order; no strobe when ce=0.
- Async reset mid-DRAW at pixel 5 of 10x10 -> all outputs return to reset values immediately; the next op draws correctly from pixel 0.
